// File: rtl/fwd_mac_sched_if.sv
// Control/strobe bundle between the forward-pass sequencer and its controller and MAC datapath.
// With SCHED_EPOCH_CNT_EN defined the bundle also carries the completed-pass counter epoch_o.
interface fwd_mac_sched_if #(
  parameter int IDX_W = 3
);
  logic             start_i;
  logic             abort_i;
  logic             mac_stall_i;
  logic             busy_o;
  logic             mac_clr_o;
  logic             mac_en_o;
  logic             mac_last_o;
  logic             mac_layer_o;
  logic [IDX_W-1:0] mac_neuron_o;
  logic [IDX_W-1:0] mac_idx_o;
  logic             store_o;
  logic             done_o;
`ifdef SCHED_EPOCH_CNT_EN
  logic [7:0]       epoch_o;
`endif

  // Controller side: requests passes and reports datapath back-pressure.
  modport master (
    output start_i, abort_i, mac_stall_i,
    input  busy_o, mac_clr_o, mac_en_o, mac_last_o, mac_layer_o,
    input  mac_neuron_o, mac_idx_o, store_o, done_o
`ifdef SCHED_EPOCH_CNT_EN
    , input epoch_o
`endif
  );

  // Sequencer side.
  modport slave (
    input  start_i, abort_i, mac_stall_i,
    output busy_o, mac_clr_o, mac_en_o, mac_last_o, mac_layer_o,
    output mac_neuron_o, mac_idx_o, store_o, done_o
`ifdef SCHED_EPOCH_CNT_EN
    , output epoch_o
`endif
  );
endinterface

// File: rtl/fwd_mac_sched.sv
// Forward-pass sequencer driving one shared MAC: every hidden neuron over all inputs, then the
// output neuron over all hidden activations. Optional SCHED_EPOCH_CNT_EN adds an 8-bit pass counter.
module fwd_mac_sched #(
  parameter int N_IN  = 4,
  parameter int N_HID = 2,
  parameter int IDX_W = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fwd_mac_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] HID_LAST = IDX_W'(N_HID - 1);

  state_t           state_q, state_d;
  logic             layer_q, layer_d;
  logic [IDX_W-1:0] neuron_q, neuron_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] term_last;
  logic             at_last;
  logic             mac_fire;

  // Hidden neurons sum N_IN terms; the output neuron sums one term per hidden activation.
  assign term_last = layer_q ? HID_LAST : IN_LAST;
  assign at_last   = (idx_q == term_last);
  assign mac_fire  = (state_q == S_MAC) && !bus.mac_stall_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      layer_q  <= 1'b0;
      neuron_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      idx_q    <= idx_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    idx_d    = idx_q;

    if (bus.abort_i && (state_q != S_IDLE)) begin
      // Abort outranks stall and the STORE/DONE exits, so no strobe follows it.
      state_d  = S_IDLE;
      layer_d  = 1'b0;
      neuron_d = '0;
      idx_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            state_d = S_CLR;
          end
        end
        S_CLR: begin
          state_d = S_MAC;
          idx_d   = '0;
        end
        S_MAC: begin
          if (!bus.mac_stall_i) begin
            if (at_last) begin
              state_d = S_STORE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        S_STORE: begin
          if (layer_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLR;
            if (neuron_q == HID_LAST) begin
              layer_d  = 1'b1;
              neuron_d = '0;
            end else begin
              neuron_d = neuron_q + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          state_d  = S_IDLE;
          layer_d  = 1'b0;
          neuron_d = '0;
          idx_d    = '0;
        end
        default: begin
          state_d  = S_IDLE;
          layer_d  = 1'b0;
          neuron_d = '0;
          idx_d    = '0;
        end
      endcase
    end
  end

  // Strobes decode straight from the state flops; only mac_en_o also looks at the stall input.
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.mac_clr_o    = (state_q == S_CLR);
  assign bus.mac_en_o     = mac_fire;
  assign bus.mac_last_o   = (state_q == S_MAC) && at_last;
  assign bus.store_o      = (state_q == S_STORE);
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.mac_layer_o  = layer_q;
  assign bus.mac_neuron_o = neuron_q;
  assign bus.mac_idx_o    = idx_q;

`ifdef SCHED_EPOCH_CNT_EN
  logic [7:0] epoch_q;

  // Counts only passes that reach DONE without an abort; wraps naturally at 8 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      epoch_q <= 8'd0;
    end else if ((state_q == S_DONE) && !bus.abort_i) begin
      epoch_q <= epoch_q + 8'd1;
    end
  end

  assign bus.epoch_o = epoch_q;
`endif

endmodule

// File: tb/tb_fwd_mac_sched.sv
// Directed bench for fwd_mac_sched: cycle-by-cycle strobe/index checks over whole passes,
// stall, abort, held start, async reset and (with SCHED_EPOCH_CNT_EN) the pass counter.
module tb_fwd_mac_sched;
  localparam int N_IN  = 4;
  localparam int N_HID = 2;
  localparam int IDX_W = 3;
  localparam int VW    = 7 + 2 * IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_mac_sched_if #(.IDX_W(IDX_W)) bus ();

  fwd_mac_sched #(
    .N_IN (N_IN),
    .N_HID(N_HID),
    .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] exp_q[$];
  logic          stall_q[$];

  // {busy, clr, en, last, store, done, layer, neuron, idx}
  function automatic logic [VW-1:0] ev(input logic busy, clr, en, last, store, done, layer,
                                       input int neuron, input int idx);
    return {busy, clr, en, last, store, done, layer, IDX_W'(neuron), IDX_W'(idx)};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bus.busy_o, bus.mac_clr_o, bus.mac_en_o, bus.mac_last_o, bus.store_o,
            bus.done_o, bus.mac_layer_o, bus.mac_neuron_o, bus.mac_idx_o};
  endfunction

  // Expected outputs for cycles 1..N after a start, plus the trailing IDLE cycle.
  // A stall of stall_len cycles is inserted at hidden neuron stall_n, term stall_at.
  task automatic gen_pass(input int stall_n, input int stall_at, input int stall_len);
    exp_q.delete();
    stall_q.delete();
    for (int n = 0; n < N_HID; n++) begin
      exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, n, 0)); stall_q.push_back(1'b0);
      for (int i = 0; i < N_IN; i++) begin
        if (n == stall_n && i == stall_at) begin
          for (int s = 0; s < stall_len; s++) begin
            exp_q.push_back(ev(1, 0, 0, i == N_IN - 1, 0, 0, 0, n, i)); stall_q.push_back(1'b1);
          end
        end
        exp_q.push_back(ev(1, 0, 1, i == N_IN - 1, 0, 0, 0, n, i)); stall_q.push_back(1'b0);
      end
      exp_q.push_back(ev(1, 0, 0, 0, 1, 0, 0, n, 0)); stall_q.push_back(1'b0);
    end
    exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 1, 0, 0)); stall_q.push_back(1'b0);
    for (int i = 0; i < N_HID; i++) begin
      exp_q.push_back(ev(1, 0, 1, i == N_HID - 1, 0, 0, 1, 0, i)); stall_q.push_back(1'b0);
    end
    exp_q.push_back(ev(1, 0, 0, 0, 1, 0, 1, 0, 0)); stall_q.push_back(1'b0);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 1, 1, 0, 0)); stall_q.push_back(1'b0);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0)); stall_q.push_back(1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.mac_stall_i = 1'b0;
    rst = 1'b1;
    #12;
    checks++;
    if (obs() !== '0)
      $display("FAIL reset_outputs: got %b want %b", obs(), {VW{1'b0}});
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    checks++;
    if (obs() !== '0)
      $display("FAIL idle_after_reset: got %b want %b", obs(), {VW{1'b0}});
    if (obs() !== '0) errors++;
  endtask

  task automatic test_single_pass();
    gen_pass(-1, 0, 0);
    bus.start_i = 1'b1;
    next_cycle();
    bus.start_i = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      bus.mac_stall_i = stall_q[k];
      #1;
      checks++;
      if (obs() !== exp_q[k]) begin
        errors++;
        $display("FAIL single_pass cycle %0d: got %b want %b", k + 1, obs(), exp_q[k]);
      end
      next_cycle();
    end
    bus.mac_stall_i = 1'b0;
  endtask

  task automatic test_stall();
    int clr_cnt, store_cnt, done_at;
    clr_cnt = 0; store_cnt = 0; done_at = -1;
    gen_pass(1, 2, 3);
    bus.start_i = 1'b1;
    next_cycle();
    bus.start_i = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      bus.mac_stall_i = stall_q[k];
      #1;
      if (bus.mac_clr_o) clr_cnt++;
      if (bus.store_o) store_cnt++;
      if (bus.done_o) done_at = k + 1;
      checks++;
      if (obs() !== exp_q[k]) begin
        errors++;
        $display("FAIL stall cycle %0d: got %b want %b", k + 1, obs(), exp_q[k]);
      end
      next_cycle();
    end
    bus.mac_stall_i = 1'b0;
    checks++;
    if (done_at !== 20) begin
      errors++;
      $display("FAIL stall_done_cycle: got %0d want 20", done_at);
    end
    checks++;
    if (clr_cnt !== 3 || store_cnt !== 3) begin
      errors++;
      $display("FAIL stall_strobe_counts: got clr=%0d store=%0d want 3/3", clr_cnt, store_cnt);
    end
  endtask

  task automatic test_abort();
    int strobes;
    strobes = 0;
    gen_pass(-1, 0, 0);
    bus.start_i = 1'b1;
    next_cycle();
    bus.start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) bus.abort_i = 1'b1;
      #1;
      checks++;
      if (obs() !== exp_q[k]) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got %b want %b", k + 1, obs(), exp_q[k]);
      end
      next_cycle();
    end
    bus.abort_i = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL abort_idle: got %b want %b", obs(), {VW{1'b0}});
    end
    for (int c = 0; c < 20; c++) begin
      if (bus.store_o || bus.done_o || bus.busy_o) strobes++;
      next_cycle();
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL abort_no_strobe: got %0d active cycles want 0", strobes);
    end
    test_single_pass();
  endtask

  task automatic test_start_held();
    gen_pass(-1, 0, 0);
    bus.start_i = 1'b1;
    next_cycle();
    for (int k = 0; k < exp_q.size(); k++) begin
      #1;
      checks++;
      if (obs() !== exp_q[k]) begin
        errors++;
        $display("FAIL start_held cycle %0d: got %b want %b", k + 1, obs(), exp_q[k]);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (obs() !== ev(1, 1, 0, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL start_held_restart: got %b want %b", obs(), ev(1, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    bus.abort_i = 1'b1;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (obs() !== '0) begin
        errors++;
        $display("FAIL start_abort_idle cycle %0d: got %b want %b", c, obs(), {VW{1'b0}});
      end
      next_cycle();
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_async_reset();
    int active;
    active = 0;
    bus.start_i = 1'b1;
    next_cycle();
    bus.start_i = 1'b0;
    next_cycle();
    next_cycle();
    #3;
    checks++;
    if (bus.mac_en_o !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_mac: got en=%b want 1", bus.mac_en_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b want %b", obs(), {VW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      next_cycle();
      if (bus.done_o || bus.busy_o) active++;
    end
    checks++;
    if (active !== 0) begin
      errors++;
      $display("FAIL async_no_done: got %0d active cycles want 0", active);
    end
  endtask

`ifdef SCHED_EPOCH_CNT_EN
  task automatic test_epoch();
    bit seen;
    checks++;
    if (bus.epoch_o !== 8'd0) begin
      errors++;
      $display("FAIL epoch_reset: got %0d want 0", bus.epoch_o);
    end
    for (int p = 0; p < 257; p++) begin
      bus.start_i = 1'b1;
      next_cycle();
      bus.start_i = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        if (bus.done_o) seen = 1'b1;
        else next_cycle();
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL epoch_done_timeout: pass %0d got no done want done", p);
      end
      if (p == 0) begin
        checks++;
        if (bus.epoch_o !== 8'd0) begin
          errors++;
          $display("FAIL epoch_in_done: got %0d want 0", bus.epoch_o);
        end
      end
      next_cycle();
      if (p == 0) begin
        checks++;
        if (bus.epoch_o !== 8'd1) begin
          errors++;
          $display("FAIL epoch_after_done: got %0d want 1", bus.epoch_o);
        end
      end
    end
    checks++;
    if (bus.epoch_o !== 8'd1) begin
      errors++;
      $display("FAIL epoch_wrap: got %0d want 1", bus.epoch_o);
    end
    bus.start_i = 1'b1;
    next_cycle();
    bus.start_i = 1'b0;
    for (int c = 0; c < 5; c++) next_cycle();
    bus.abort_i = 1'b1;
    next_cycle();
    bus.abort_i = 1'b0;
    for (int c = 0; c < 20; c++) next_cycle();
    checks++;
    if (bus.epoch_o !== 8'd1) begin
      errors++;
      $display("FAIL epoch_abort: got %0d want 1", bus.epoch_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_stall();
    test_abort();
    test_start_held();
    test_async_reset();
`ifdef SCHED_EPOCH_CNT_EN
    test_epoch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
